// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register for the ARM32 core.
// Holds up to two in-flight entries (head + skid) when SKID=1, or a single
// head entry when SKID=0. The head entry drives the writeback stage. Freeze
// holds everything and masks the handshake qualifiers. Flush drops all
// entries. A saturating counter records the cycles in which WB applies
// backpressure.
module mem_wb_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int DEST_W = 4,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              wb_en_in,
   input  logic              mem_r_en_in,
   input  logic [DATA_W-1:0] alu_res_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DEST_W-1:0] dest_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              wb_en_out,
   output logic              mem_r_en_out,
   output logic [DATA_W-1:0] alu_res_out,
   output logic [DATA_W-1:0] data_out,
   output logic [DEST_W-1:0] dest_out,
   output logic [DATA_W-1:0] wb_value_out,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] data;
      logic [DEST_W-1:0] dest;
   } entry_t;

   // Counter increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}})
         return v;
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Writeback value selection: loads write memory data, others the ALU result.
   function automatic logic [DATA_W-1:0] wb_mux(input entry_t e);
      return e.mem_r_en ? e.data : e.alu;
   endfunction

   entry_t            r_hd;
   entry_t            r_sk;
   logic              r_hd_vld;
   logic              r_sk_vld;
   logic [CNT_W-1:0]  r_stall_cnt;

   entry_t            w_in_ent;
   entry_t            w_hd_nxt;
   entry_t            w_sk_nxt;
   logic              w_hd_vld_nxt;
   logic              w_sk_vld_nxt;
   logic              w_in_ready;
   logic              w_out_valid;
   logic              w_acc;
   logic              w_con;
   logic              w_stall;

   assign w_in_ent = {wb_en_in, mem_r_en_in, alu_res_in, data_in, dest_in};

   // Handshake qualifiers. With the skid buffer, in_ready depends only on
   // registered state (and freeze), so the ready path from WB is cut.
   always_comb begin
      w_out_valid = r_hd_vld & ~freeze;
      if (SKID != 0)
         w_in_ready = ~r_sk_vld & ~freeze;
      else
         w_in_ready = (~r_hd_vld | out_ready) & ~freeze;
      w_acc   = in_valid & w_in_ready;
      w_con   = w_out_valid & out_ready;
      w_stall = w_out_valid & ~out_ready;
   end

   // Next-state selection for head and skid entries (flush > freeze > update).
   always_comb begin
      w_hd_nxt     = r_hd;
      w_sk_nxt     = r_sk;
      w_hd_vld_nxt = r_hd_vld;
      w_sk_vld_nxt = r_sk_vld;
      if (flush) begin
         w_hd_vld_nxt = 1'b0;
         w_sk_vld_nxt = 1'b0;
      end else if (!freeze) begin
         if (SKID != 0) begin
            if (r_hd_vld && !w_con) begin
               // Head is stuck: a new entry parks in the skid slot.
               if (w_acc) begin
                  w_sk_nxt     = w_in_ent;
                  w_sk_vld_nxt = 1'b1;
               end
            end else if (r_sk_vld) begin
               // Head left (or was empty): the older skid entry moves up.
               // in_ready was low, so no new entry can arrive this edge.
               w_hd_nxt     = r_sk;
               w_hd_vld_nxt = 1'b1;
               w_sk_vld_nxt = 1'b0;
            end else if (w_acc) begin
               w_hd_nxt     = w_in_ent;
               w_hd_vld_nxt = 1'b1;
            end else begin
               w_hd_vld_nxt = 1'b0;
            end
         end else begin
            if (w_acc) begin
               w_hd_nxt     = w_in_ent;
               w_hd_vld_nxt = 1'b1;
            end else if (w_con) begin
               w_hd_vld_nxt = 1'b0;
            end
         end
      end
   end

   // State registers and stall counter; reset clears every field.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hd        <= '0;
         r_sk        <= '0;
         r_hd_vld    <= 1'b0;
         r_sk_vld    <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_hd     <= w_hd_nxt;
         r_sk     <= w_sk_nxt;
         r_hd_vld <= w_hd_vld_nxt;
         r_sk_vld <= w_sk_vld_nxt;
         if (w_stall)
            r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end

   // Output drive from the head entry; wb_en is gated so bubbles never write.
   always_comb begin
      in_ready     = w_in_ready;
      out_valid    = w_out_valid;
      wb_en_out    = r_hd.wb_en & w_out_valid;
      mem_r_en_out = r_hd.mem_r_en;
      alu_res_out  = r_hd.alu;
      data_out     = r_hd.data;
      dest_out     = r_hd.dest;
      wb_value_out = wb_mux(r_hd);
      stall_cnt    = r_stall_cnt;
   end

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: three instances (skid/16-bit counter, no skid,
// skid/4-bit counter) share one stimulus stream and are compared each cycle
// against a FIFO-style reference model.
module tb_mem_wb_pipe_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, freeze, flush, in_valid, wb_en_in, mem_r_en_in, out_ready;
   logic [31:0] alu_res_in, data_in;
   logic [3:0]  dest_in;

   logic        ir  [3];
   logic        ov  [3];
   logic        wbe [3];
   logic        mre [3];
   logic [31:0] alu_o  [3];
   logic [31:0] data_o [3];
   logic [31:0] wbv    [3];
   logic [3:0]  dest_o [3];
   logic [15:0] cnt0, cnt1;
   logic [3:0]  cnt2;

   int n_checks = 0;
   int n_err    = 0;

   mem_wb_pipe_reg #(.DATA_W(32), .DEST_W(4), .SKID(1), .CNT_W(16)) u_skid (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[0]),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
      .alu_res_in(alu_res_in), .data_in(data_in), .dest_in(dest_in),
      .out_valid(ov[0]), .out_ready(out_ready),
      .wb_en_out(wbe[0]), .mem_r_en_out(mre[0]),
      .alu_res_out(alu_o[0]), .data_out(data_o[0]), .dest_out(dest_o[0]),
      .wb_value_out(wbv[0]), .stall_cnt(cnt0));

   mem_wb_pipe_reg #(.DATA_W(32), .DEST_W(4), .SKID(0), .CNT_W(16)) u_noskid (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[1]),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
      .alu_res_in(alu_res_in), .data_in(data_in), .dest_in(dest_in),
      .out_valid(ov[1]), .out_ready(out_ready),
      .wb_en_out(wbe[1]), .mem_r_en_out(mre[1]),
      .alu_res_out(alu_o[1]), .data_out(data_o[1]), .dest_out(dest_o[1]),
      .wb_value_out(wbv[1]), .stall_cnt(cnt1));

   mem_wb_pipe_reg #(.DATA_W(32), .DEST_W(4), .SKID(1), .CNT_W(4)) u_cnt4 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[2]),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
      .alu_res_in(alu_res_in), .data_in(data_in), .dest_in(dest_in),
      .out_valid(ov[2]), .out_ready(out_ready),
      .wb_en_out(wbe[2]), .mem_r_en_out(mre[2]),
      .alu_res_out(alu_o[2]), .data_out(data_o[2]), .dest_out(dest_o[2]),
      .wb_value_out(wbv[2]), .stall_cnt(cnt2));

   // Reference model: each instance is a FIFO of capacity 2 (skid) or 1.
   typedef struct {
      logic        wb;
      logic        mr;
      logic [31:0] alu;
      logic [31:0] data;
      logic [3:0]  dest;
   } ent_t;

   ent_t mq   [3][2];
   int   msz  [3];
   int   mcnt [3];

   function automatic int cap(input int d);
      return (d == 1) ? 1 : 2;
   endfunction

   function automatic int cnt_max(input int d);
      return (d == 2) ? 15 : 65535;
   endfunction

   function automatic logic m_ov(input int d);
      return !freeze && (msz[d] > 0);
   endfunction

   function automatic logic m_ir(input int d);
      if (freeze) return 1'b0;
      if (cap(d) == 1) return (msz[d] == 0) || out_ready;
      return msz[d] < cap(d);
   endfunction

   function automatic logic [31:0] cnt_of(input int d);
      case (d)
         0:       return {16'h0, cnt0};
         1:       return {16'h0, cnt1};
         default: return {28'h0, cnt2};
      endcase
   endfunction

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, d, obs, exp);
      end
   endtask

   task automatic check_cycle();
      for (int d = 0; d < 3; d++) begin
         logic eov;
         eov = m_ov(d);
         chk("out_valid", d, ov[d], eov);
         chk("in_ready", d, ir[d], m_ir(d));
         chk("stall_cnt", d, cnt_of(d), mcnt[d]);
         if (msz[d] > 0) begin
            chk("wb_en_out", d, wbe[d], mq[d][0].wb & eov);
            chk("mem_r_en_out", d, mre[d], mq[d][0].mr);
            chk("alu_res_out", d, alu_o[d], mq[d][0].alu);
            chk("data_out", d, data_o[d], mq[d][0].data);
            chk("dest_out", d, dest_o[d], mq[d][0].dest);
            chk("wb_value_out", d, wbv[d], mq[d][0].mr ? mq[d][0].data : mq[d][0].alu);
         end else begin
            chk("wb_en_out", d, wbe[d], 1'b0);
         end
      end
   endtask

   task automatic model_edge();
      for (int d = 0; d < 3; d++) begin
         logic acc, con;
         acc = in_valid && m_ir(d);
         con = m_ov(d) && out_ready;
         if (rst) begin
            msz[d]  = 0;
            mcnt[d] = 0;
         end else begin
            if (m_ov(d) && !out_ready && mcnt[d] < cnt_max(d)) mcnt[d]++;
            if (flush) begin
               msz[d] = 0;
            end else if (!freeze) begin
               if (con) begin
                  mq[d][0] = mq[d][1];
                  msz[d]--;
               end
               if (acc) begin
                  mq[d][msz[d]] = '{wb_en_in, mem_r_en_in, alu_res_in, data_in, dest_in};
                  msz[d]++;
               end
            end
         end
      end
   endtask

   task automatic look();
      @(negedge clk);
      check_cycle();
   endtask

   task automatic edge_();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic tick();
      look();
      edge_();
   endtask

   task automatic push(input logic wb, input logic mr, input logic [31:0] alu,
                       input logic [31:0] dat, input logic [3:0] dst);
      in_valid    = 1'b1;
      wb_en_in    = wb;
      mem_r_en_in = mr;
      alu_res_in  = alu;
      data_in     = dat;
      dest_in     = dst;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      wb_en_in = 1'b0; mem_r_en_in = 1'b0; alu_res_in = '0; data_in = '0; dest_in = '0;
      for (int d = 0; d < 3; d++) begin msz[d] = 0; mcnt[d] = 0; end
      repeat (2) edge_();
      rst = 1'b0;

      // Reset / idle
      look();
      for (int d = 0; d < 3; d++) begin
         chk("idle_out_valid", d, ov[d], 1'b0);
         chk("idle_in_ready", d, ir[d], 1'b1);
         chk("idle_stall_cnt", d, cnt_of(d), 32'h0);
         chk("idle_wb_value", d, wbv[d], 32'h0);
      end
      edge_();

      // Streaming
      out_ready = 1'b1;
      push(1'b1, 1'b0, 32'h10, 32'h1111, 4'd1); tick();
      push(1'b1, 1'b0, 32'h20, 32'h2222, 4'd2); tick();
      push(1'b1, 1'b0, 32'h30, 32'h3333, 4'd3); tick();
      in_valid = 1'b0;
      look();
      for (int d = 0; d < 3; d++) chk("stream_last_wb_value", d, wbv[d], 32'h30);
      edge_();
      tick();

      // Backpressure
      out_ready = 1'b0;
      push(1'b1, 1'b1, 32'h100, 32'hAAAA, 4'd7); tick();
      push(1'b1, 1'b0, 32'h200, 32'hBBBB, 4'd8); tick();
      push(1'b1, 1'b0, 32'h300, 32'hCCCC, 4'd9);
      look();
      chk("bp_in_ready_full", 0, ir[0], 1'b0);
      chk("bp_head_is_A", 0, wbv[0], 32'hAAAA);
      edge_();
      in_valid = 1'b0;
      tick();
      out_ready = 1'b1;
      repeat (4) tick();

      // Freeze
      do_reset();
      out_ready = 1'b0;
      push(1'b1, 1'b0, 32'h55, 32'h5555, 4'd5); tick();
      freeze = 1'b1;
      push(1'b1, 1'b0, 32'h66, 32'h6666, 4'd6);
      repeat (3) tick();
      freeze = 1'b0; in_valid = 1'b0;
      look();
      chk("freeze_dest_back", 0, dest_o[0], 4'd5);
      chk("freeze_valid_back", 0, ov[0], 1'b1);
      edge_();

      // Flush with both entries held
      push(1'b1, 1'b1, 32'h77, 32'h7777, 4'd7); tick();
      in_valid = 1'b0; tick();
      flush = 1'b1; freeze = 1'b1;
      push(1'b1, 1'b0, 32'h88, 32'h8888, 4'd8); tick();
      flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
      look();
      for (int d = 0; d < 3; d++) begin
         chk("flush_out_valid", d, ov[d], 1'b0);
         chk("flush_wb_en", d, wbe[d], 1'b0);
         chk("flush_in_ready", d, ir[d], 1'b1);
      end
      edge_();

      // Counter saturation
      do_reset();
      out_ready = 1'b0;
      push(1'b1, 1'b0, 32'h99, 32'h9999, 4'd9); tick();
      in_valid = 1'b0;
      repeat (20) tick();
      look();
      chk("sat_cnt4", 2, cnt_of(2), 32'd15);
      edge_();
      rst = 1'b1; tick();
      rst = 1'b0;
      look();
      chk("sat_cnt4_reset", 2, cnt_of(2), 32'd0);
      edge_();

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 63) == 0);
         freeze    = ($urandom_range(0, 7) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         out_ready = $urandom_range(0, 1);
         push($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, 4'($urandom));
         in_valid  = $urandom_range(0, 1);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
